// File: rtl/multi_clock_suite_handshake_sink_pkg.sv
// Shared definitions for the handshake sink: default geometry and FSM state encodings.
package multi_clock_suite_handshake_sink_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_CNTW  = 16;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

endpackage

// File: rtl/multi_clock_suite_handshake_sink_if.sv
// Upstream/downstream stream bundle of the handshake sink.
//  master: drives io_in_valid/io_in_bits, io_out_ready, io_flush (the surrounding test component)
//  slave : drives io_in_ready, io_out_valid/io_out_bits, io_count, io_accepted (the sink)
interface multi_clock_suite_handshake_sink_if
  import multi_clock_suite_handshake_sink_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CNTW  = DEF_CNTW
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             io_in_valid;
  logic [WIDTH-1:0] io_in_bits;
  logic             io_in_ready;
  logic             io_out_valid;
  logic [WIDTH-1:0] io_out_bits;
  logic             io_out_ready;
  logic             io_flush;
  logic [CW-1:0]    io_count;
  logic [CNTW-1:0]  io_accepted;

  modport master (
    output io_in_valid, io_in_bits, io_out_ready, io_flush,
    input  io_in_ready, io_out_valid, io_out_bits, io_count, io_accepted
  );

  modport slave (
    input  io_in_valid, io_in_bits, io_out_ready, io_flush,
    output io_in_ready, io_out_valid, io_out_bits, io_count, io_accepted
  );

endinterface

// File: rtl/multi_clock_suite_rx_fifo.sv
// DEPTH-entry circular buffer with push/pop/clear; head and valid are combinational.
//  clk_i, rst_ni        : clock, synchronous active-low reset
//  push_i, push_data_i  : write a beat (caller guarantees not full)
//  pop_i                : retire the head (caller guarantees not empty)
//  clear_i              : drop all entries, overrides push/pop
//  head_c_o, valid_c_o  : head data / non-empty
//  count_o              : registered occupancy; count_next_c_o is its next value
module multi_clock_suite_rx_fifo
  import multi_clock_suite_handshake_sink_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  output logic [WIDTH-1:0]           head_c_o,
  output logic                       valid_c_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [$clog2(DEPTH):0]     count_next_c_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointers wrap naturally at DEPTH (power of two); count separates full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; contents are only observable while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_c_o       = mem_q[rd_ptr_q];
  assign valid_c_o      = (count_q != '0);
  assign count_o        = count_q;
  assign count_next_c_o = count_d;

endmodule

// File: rtl/multi_clock_suite_handshake_sink.sv
// Receiving end of a valid/ready stream: registered ready, DEPTH-entry buffer,
// accepted-beat counter and a one-cycle synchronous flush.
//  C0    : clock
//  reset : synchronous active-low reset
//  bus   : stream bundle (slave side), see multi_clock_suite_handshake_sink_if
module multi_clock_suite_handshake_sink
  import multi_clock_suite_handshake_sink_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CNTW  = DEF_CNTW
) (
  input  logic                                  C0,
  input  logic                                  reset,
  multi_clock_suite_handshake_sink_if.slave     bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [0:0]       state_q, state_d;
  logic             ready_q, ready_d;
  logic [CNTW-1:0]  accepted_q, accepted_d;
  logic             acc_c, pop_c;
  logic             fifo_valid;
  logic [WIDTH-1:0] fifo_head;
  logic [CW-1:0]    fifo_count, fifo_count_next;

  // A flush edge ignores traffic entirely, including an otherwise valid accept.
  assign acc_c = bus.io_in_valid & ready_q & (state_q == ST_RUN) & ~bus.io_flush;
  assign pop_c = fifo_valid & bus.io_out_ready & ~bus.io_flush;

  // Next-state: flush holds FLUSH for as long as it is asserted, then returns to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (bus.io_flush) state_d = ST_FLUSH;
      ST_FLUSH: state_d = bus.io_flush ? ST_FLUSH : ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Ready looks one cycle ahead so it can be registered without overflowing.
  assign ready_d    = (state_d == ST_RUN) & (fifo_count_next < CW'(DEPTH));
  assign accepted_d = acc_c ? accepted_q + CNTW'(1) : accepted_q;

  always_ff @(posedge C0) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      ready_q    <= 1'b0;
      accepted_q <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      accepted_q <= accepted_d;
    end
  end

  multi_clock_suite_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i          (C0),
    .rst_ni         (reset),
    .push_i         (acc_c),
    .push_data_i    (bus.io_in_bits),
    .pop_i          (pop_c),
    .clear_i        (bus.io_flush),
    .head_c_o       (fifo_head),
    .valid_c_o      (fifo_valid),
    .count_o        (fifo_count),
    .count_next_c_o (fifo_count_next)
  );

  assign bus.io_in_ready  = ready_q;
  assign bus.io_out_valid = fifo_valid;
  assign bus.io_out_bits  = fifo_head;
  assign bus.io_count     = fifo_count;
  assign bus.io_accepted  = accepted_q;

endmodule

// File: tb/tb_multi_clock_suite_handshake_sink.sv
// Bench for the handshake sink: directed stimulus, queue scoreboard checked by a negedge monitor.
module tb_multi_clock_suite_handshake_sink;

  logic C0    = 1'b0;
  logic reset = 1'b0;

  always #5 C0 = ~C0;

  multi_clock_suite_handshake_sink_if #(.WIDTH(8), .DEPTH(4), .CNTW(16)) bus ();

  multi_clock_suite_handshake_sink #(.WIDTH(8), .DEPTH(4), .CNTW(16)) dut (
    .C0    (C0),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of the sink, advanced at each negedge for the coming posedge.
  logic [7:0]  sb_q[$];
  int          m_cnt = 0;
  bit          m_rdy = 1'b0;
  bit          m_run = 1'b1;
  logic [15:0] m_acc = 16'h0;
  bit          mon_en = 1'b0;

  always @(negedge C0) begin
    bit acc, pop;
    if (mon_en) begin
      chk("in_ready",  32'(bus.io_in_ready),  32'(m_rdy));
      chk("count",     32'(bus.io_count),     32'(m_cnt));
      chk("out_valid", 32'(bus.io_out_valid), 32'(m_cnt != 0));
      chk("accepted",  32'(bus.io_accepted),  32'(m_acc));
    end
    acc = bus.io_in_valid && m_rdy && m_run && !bus.io_flush;
    pop = (m_cnt != 0) && bus.io_out_ready && !bus.io_flush;
    if (mon_en && reset && pop) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL out_bits: got 0x%0h expected none (scoreboard empty) at %0t", bus.io_out_bits, $time);
      end else begin
        chk("out_bits", 32'(bus.io_out_bits), 32'(sb_q[0]));
        void'(sb_q.pop_front());
      end
    end
    if (!reset) begin
      m_cnt = 0; m_rdy = 1'b0; m_run = 1'b1; m_acc = 16'h0;
      sb_q.delete();
    end else if (bus.io_flush) begin
      m_cnt = 0; m_rdy = 1'b0; m_run = 1'b0;
      sb_q.delete();
    end else begin
      if (acc) begin
        sb_q.push_back(bus.io_in_bits);
        m_acc = m_acc + 16'd1;
      end
      m_cnt = m_cnt + int'(acc) - int'(pop);
      m_run = 1'b1;
      m_rdy = (m_cnt < 4);
    end
  end

  task automatic step();
    @(posedge C0);
    #1;
  endtask

  initial begin
    int maxc;
    bus.io_in_valid  = 1'b0;
    bus.io_in_bits   = 8'h00;
    bus.io_out_ready = 1'b0;
    bus.io_flush     = 1'b0;
    reset            = 1'b0;
    step();
    step();
    mon_en = 1'b1;

    // Reset state, then ready rises one cycle after release.
    chk("rst_ready",    32'(bus.io_in_ready),  32'd0);
    chk("rst_count",    32'(bus.io_count),     32'd0);
    chk("rst_valid",    32'(bus.io_out_valid), 32'd0);
    chk("rst_accepted", 32'(bus.io_accepted),  32'd0);
    reset = 1'b1;
    step();
    chk("ready_cycle2", 32'(bus.io_in_ready), 32'd1);

    // Fill to DEPTH with no downstream drain.
    bus.io_in_valid = 1'b1;
    bus.io_in_bits = 8'h11; step();
    bus.io_in_bits = 8'h22; step();
    bus.io_in_bits = 8'h33; step();
    bus.io_in_bits = 8'h44; step();
    chk("full_count", 32'(bus.io_count),    32'd4);
    chk("full_ready", 32'(bus.io_in_ready), 32'd0);
    bus.io_in_bits = 8'h55; step();
    chk("held_off_count",    32'(bus.io_count),    32'd4);
    chk("held_off_accepted", 32'(bus.io_accepted), 32'd4);

    // Pop while 0x55 is offered: ready was low, so only the pop happens.
    bus.io_out_ready = 1'b1; step();
    chk("head_after_pop",  32'(bus.io_out_bits), 32'h22);
    chk("count_after_pop", 32'(bus.io_count),    32'd3);
    bus.io_out_ready = 1'b0; step();
    chk("refill_count", 32'(bus.io_count),    32'd4);
    chk("refill_ready", 32'(bus.io_in_ready), 32'd0);
    bus.io_in_valid = 1'b0;
    bus.io_out_ready = 1'b1;
    repeat (4) step();
    bus.io_out_ready = 1'b0;
    chk("drained_count",    32'(bus.io_count),    32'd0);
    chk("drained_accepted", 32'(bus.io_accepted), 32'd5);

    // Streaming: push and pop every cycle for 20 beats.
    reset = 1'b0; step();
    reset = 1'b1; step();
    bus.io_out_ready = 1'b1;
    maxc = 0;
    for (int i = 0; i < 20; i++) begin
      bus.io_in_valid = 1'b1;
      bus.io_in_bits  = 8'(8'hA0 + i);
      step();
      if (int'(bus.io_count) > maxc) maxc = int'(bus.io_count);
    end
    bus.io_in_valid = 1'b0;
    step(); step();
    chk("stream_max_count", 32'(maxc),             32'd1);
    chk("stream_accepted",  32'(bus.io_accepted),  32'd20);
    chk("stream_count",     32'(bus.io_count),     32'd0);
    chk("stream_sb_empty",  32'(sb_q.size()),      32'd0);

    // Flush with three buffered beats and a beat on offer.
    bus.io_out_ready = 1'b0;
    bus.io_in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.io_in_bits = 8'(8'h31 + i);
      step();
    end
    chk("pre_flush_count", 32'(bus.io_count), 32'd3);
    bus.io_flush = 1'b1;
    bus.io_in_bits = 8'h99;
    step();
    chk("flush_count",    32'(bus.io_count),     32'd0);
    chk("flush_ready",    32'(bus.io_in_ready),  32'd0);
    chk("flush_valid",    32'(bus.io_out_valid), 32'd0);
    chk("flush_accepted", 32'(bus.io_accepted),  32'd23);
    bus.io_flush = 1'b0;
    step();
    chk("post_flush_ready",    32'(bus.io_in_ready), 32'd1);
    chk("post_flush_accepted", 32'(bus.io_accepted), 32'd23);
    bus.io_in_valid = 1'b0;

    // Flush held for two cycles keeps ready low for both.
    bus.io_flush = 1'b1;
    step();
    step();
    chk("dbl_flush_ready", 32'(bus.io_in_ready), 32'd0);
    bus.io_flush = 1'b0;
    step();
    chk("dbl_flush_ready_back", 32'(bus.io_in_ready), 32'd1);

    // Counter wrap: 65535 beats to 0xFFFF, one more wraps to zero.
    reset = 1'b0; step();
    reset = 1'b1; step();
    bus.io_out_ready = 1'b1;
    bus.io_in_valid  = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      bus.io_in_bits = 8'(i);
      step();
    end
    bus.io_in_valid = 1'b0;
    step(); step();
    chk("acc_ffff", 32'(bus.io_accepted), 32'h0000FFFF);
    bus.io_in_valid = 1'b1;
    bus.io_in_bits  = 8'h5A;
    step();
    bus.io_in_valid = 1'b0;
    step();
    chk("acc_wrap", 32'(bus.io_accepted), 32'h00000000);

    // Reset in the middle of a burst.
    bus.io_out_ready = 1'b0;
    bus.io_in_valid  = 1'b1;
    bus.io_in_bits = 8'h71; step();
    bus.io_in_bits = 8'h72; step();
    chk("burst_count", 32'(bus.io_count), 32'd2);
    reset = 1'b0;
    step();
    chk("midrst_count",    32'(bus.io_count),     32'd0);
    chk("midrst_ready",    32'(bus.io_in_ready),  32'd0);
    chk("midrst_valid",    32'(bus.io_out_valid), 32'd0);
    chk("midrst_accepted", 32'(bus.io_accepted),  32'd0);
    reset = 1'b1;
    bus.io_in_valid = 1'b0;
    step(); step();
    chk("midrst_ready_back", 32'(bus.io_in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
